// File: rtl/eth_irq_coalesce_unit.sv
// Per-channel interrupt coalescing: each channel raises pending once an event-count
// threshold is reached or a timeout expires after the first event, until software clears it.
module eth_irq_coalesce_unit #(
  parameter int channels_p    = 2,
  parameter int count_width_p = 8,
  parameter int timer_width_p = 16,
  localparam int chan_w_lp    = (channels_p > 1) ? $clog2(channels_p) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [channels_p-1:0]     event_v_i,
  input  logic                      cfg_v_i,
  input  logic [chan_w_lp-1:0]      cfg_chan_i,
  input  logic                      cfg_enable_i,
  input  logic [count_width_p-1:0]  cfg_threshold_i,
  input  logic [timer_width_p-1:0]  cfg_timeout_i,
  input  logic                      clear_v_i,
  input  logic [chan_w_lp-1:0]      clear_chan_i,
  input  logic                      rd_v_i,
  input  logic [chan_w_lp-1:0]      rd_chan_i,
  output logic [count_width_p-1:0]  rd_count_o,
  output logic                      rd_v_o,
  output logic [channels_p-1:0]     pending_o,
  output logic                      irq_o,
  output logic [2*channels_p-1:0]   dbg_state_o
);

  // Debug encoding on dbg_state_o: 0 = IDLE, 1 = ACCUM, 2 = PEND (two bits per channel).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    PEND  = 2'd2
  } state_t;

  logic [count_width_p-1:0] count_w [channels_p];
  logic [channels_p-1:0]    pend_d;

  logic [count_width_p-1:0] rd_count_q;
  logic                     rd_v_q;
  logic [channels_p-1:0]    pending_q;
  logic                     irq_q;

  for (genvar g = 0; g < channels_p; g++) begin : g_chan
    state_t                   state_q, state_d, base_state;
    logic [count_width_p-1:0] count_q, count_d, base_count, count_inc;
    logic [count_width_p-1:0] thr_q, thr_d, thr_eff;
    logic [timer_width_p-1:0] timer_q, timer_d, base_timer;
    logic [timer_width_p-1:0] tmo_q, tmo_d;
    logic                     en_q, en_d;
    logic                     clr_hit, cfg_hit, ev_hit, thr_hit, tmo_hit;

    always_comb begin
      clr_hit    = clear_v_i && (clear_chan_i == chan_w_lp'(g));
      cfg_hit    = cfg_v_i && (cfg_chan_i == chan_w_lp'(g));
      ev_hit     = event_v_i[g] && en_q;
      thr_eff    = (thr_q == '0) ? count_width_p'(1) : thr_q;
      // A clear is applied before any same-cycle event, so the event restarts accumulation.
      base_state = clr_hit ? IDLE : state_q;
      base_count = clr_hit ? '0 : count_q;
      base_timer = clr_hit ? '0 : timer_q;
      count_inc  = (&base_count) ? base_count : base_count + count_width_p'(1);
      thr_hit    = ev_hit && (count_inc >= thr_eff);
      tmo_hit    = (tmo_q != '0) && (base_timer == tmo_q);

      state_d = base_state;
      count_d = ev_hit ? count_inc : base_count;
      timer_d = base_timer;
      en_d    = en_q;
      thr_d   = thr_q;
      tmo_d   = tmo_q;

      case (base_state)
        IDLE: begin
          if (ev_hit) begin
            state_d = thr_hit ? PEND : ACCUM;
            timer_d = '0;
          end
        end
        ACCUM: begin
          if (thr_hit || tmo_hit) state_d = PEND;
          else                    timer_d = base_timer + timer_width_p'(1);
        end
        default: ;
      endcase

      // Disabling wins over everything else; the new settings govern the next cycle.
      if (cfg_hit) begin
        en_d  = cfg_enable_i;
        thr_d = cfg_threshold_i;
        tmo_d = cfg_timeout_i;
        if (!cfg_enable_i) begin
          state_d = IDLE;
          count_d = '0;
          timer_d = '0;
        end
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        state_q <= IDLE;
        count_q <= '0;
        timer_q <= '0;
        en_q    <= 1'b0;
        thr_q   <= count_width_p'(1);
        tmo_q   <= '0;
      end else begin
        state_q <= state_d;
        count_q <= count_d;
        timer_q <= timer_d;
        en_q    <= en_d;
        thr_q   <= thr_d;
        tmo_q   <= tmo_d;
      end
    end

    assign count_w[g]            = count_q;
    assign pend_d[g]             = (state_d == PEND);
    assign dbg_state_o[2*g +: 2] = state_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_count_q <= '0;
      rd_v_q     <= 1'b0;
      pending_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      rd_v_q    <= rd_v_i;
      pending_q <= pend_d;
      irq_q     <= |pend_d;
      if (rd_v_i) rd_count_q <= count_w[rd_chan_i];
    end
  end

  assign rd_count_o = rd_count_q;
  assign rd_v_o     = rd_v_q;
  assign pending_o  = pending_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_eth_irq_coalesce_unit.sv
// Self-checking bench for eth_irq_coalesce_unit: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the coalescing rules.
module tb_eth_irq_coalesce_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [1:0]  event_v;
  logic        cfg_v, cfg_chan, cfg_en;
  logic [7:0]  cfg_thr;
  logic [15:0] cfg_tmo;
  logic        clear_v, clear_chan, rd_v, rd_chan;
  logic [7:0]  rd_count;
  logic        rd_vo, irq;
  logic [1:0]  pending;
  logic [3:0]  dbg;

  logic [1:0]  ev2;
  logic        cfg2_v, clear2_v, rd2_v, rd2_vo, irq2;
  logic [1:0]  thr2, rd2_count, pend2;
  logic [3:0]  dbg2;

  int total = 0;
  int bad   = 0;

  eth_irq_coalesce_unit dut (
    .clk_i(clk), .reset_n_i(reset_n), .event_v_i(event_v),
    .cfg_v_i(cfg_v), .cfg_chan_i(cfg_chan), .cfg_enable_i(cfg_en),
    .cfg_threshold_i(cfg_thr), .cfg_timeout_i(cfg_tmo),
    .clear_v_i(clear_v), .clear_chan_i(clear_chan),
    .rd_v_i(rd_v), .rd_chan_i(rd_chan), .rd_count_o(rd_count), .rd_v_o(rd_vo),
    .pending_o(pending), .irq_o(irq), .dbg_state_o(dbg)
  );

  eth_irq_coalesce_unit #(.count_width_p(2)) dut2 (
    .clk_i(clk), .reset_n_i(reset_n), .event_v_i(ev2),
    .cfg_v_i(cfg2_v), .cfg_chan_i(cfg_chan), .cfg_enable_i(cfg_en),
    .cfg_threshold_i(thr2), .cfg_timeout_i(cfg_tmo),
    .clear_v_i(clear2_v), .clear_chan_i(clear_chan),
    .rd_v_i(rd2_v), .rd_chan_i(rd_chan), .rd_count_o(rd2_count), .rd_v_o(rd2_vo),
    .pending_o(pend2), .irq_o(irq2), .dbg_state_o(dbg2)
  );

  // Behavioural model: per channel an enable/threshold/timeout, an event count, a pending
  // flag and the clock index at which accumulation began (-1 when not accumulating).
  int m_en[2], m_thr[2], m_tmo[2], m_cnt[2], m_pend[2], m_since[2];
  int cyc, m_rd_count, m_rd_v;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_en[c] = 0; m_thr[c] = 1; m_tmo[c] = 0;
      m_cnt[c] = 0; m_pend[c] = 0; m_since[c] = -1;
    end
    cyc = 0; m_rd_count = 0; m_rd_v = 0;
  endtask

  task automatic model_step();
    if (rd_v) m_rd_count = m_cnt[int'(rd_chan)];
    m_rd_v = int'(rd_v);
    for (int c = 0; c < 2; c++) begin
      int was_idle;
      int thr;
      if (clear_v && int'(clear_chan) == c) begin
        m_cnt[c] = 0; m_pend[c] = 0; m_since[c] = -1;
      end
      if (m_en[c] != 0 && event_v[c]) begin
        was_idle = (m_pend[c] == 0 && m_since[c] < 0) ? 1 : 0;
        if (m_cnt[c] < 255) m_cnt[c]++;
        thr = (m_thr[c] == 0) ? 1 : m_thr[c];
        if (m_pend[c] == 0) begin
          if (m_cnt[c] >= thr) begin
            m_pend[c] = 1; m_since[c] = -1;
          end else if (was_idle != 0) begin
            m_since[c] = cyc;
          end
        end
      end
      // Timer reads 0 at the entry edge and counts up; expiry fires the edge after it equals the timeout.
      if (m_since[c] >= 0 && m_since[c] < cyc && m_tmo[c] != 0 && cyc == m_since[c] + m_tmo[c] + 1) begin
        m_pend[c] = 1; m_since[c] = -1;
      end
      if (cfg_v && int'(cfg_chan) == c) begin
        m_en[c] = int'(cfg_en); m_thr[c] = int'(cfg_thr); m_tmo[c] = int'(cfg_tmo);
        if (!cfg_en) begin
          m_cnt[c] = 0; m_pend[c] = 0; m_since[c] = -1;
        end
      end
    end
    cyc++;
  endtask

  function automatic logic [1:0] exp_pend();
    return {m_pend[1] != 0, m_pend[0] != 0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    event_v = '0; cfg_v = 0; cfg_chan = 0; cfg_en = 0; cfg_thr = '0; cfg_tmo = '0;
    clear_v = 0; clear_chan = 0; rd_v = 0; rd_chan = 0;
    ev2 = '0; cfg2_v = 0; thr2 = '0; clear2_v = 0; rd2_v = 0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  task automatic cfg_write(input logic ch, input logic en, input logic [7:0] thr, input logic [15:0] tmo);
    cfg_v = 1; cfg_chan = ch; cfg_en = en; cfg_thr = thr; cfg_tmo = tmo;
    step();
    cfg_v = 0;
  endtask

  task automatic pulse(input logic [1:0] mask);
    event_v = mask;
    step();
    event_v = '0;
  endtask

  task automatic read_chan(input logic ch);
    rd_v = 1; rd_chan = ch;
    step();
    rd_v = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (pending !== 2'b00) begin bad++; $display("FAIL reset_pending: got %b want 00", pending); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    total++; if (rd_vo !== 1'b0 || rd_count !== 8'd0) begin bad++; $display("FAIL reset_rd: got v=%b cnt=%0d want v=0 cnt=0", rd_vo, rd_count); end
    total++; if (dbg !== 4'd0) begin bad++; $display("FAIL reset_state: got %h want 0", dbg); end
    reset_n = 1;
    pulse(2'b11);
    read_chan(0);
    total++; if (rd_vo !== 1'b1 || rd_count !== 8'(m_rd_count)) begin bad++; $display("FAIL reset_disabled_count: got v=%b cnt=%0d want v=1 cnt=%0d", rd_vo, rd_count, m_rd_count); end
    total++; if (pending !== exp_pend()) begin bad++; $display("FAIL reset_disabled_pend: got %b want %b", pending, exp_pend()); end
  endtask

  task automatic test_threshold();
    do_reset();
    cfg_write(0, 1, 8'd4, 16'd0);
    for (int i = 1; i <= 4; i++) begin
      pulse(2'b01);
      total++; if (pending[0] !== (i == 4)) begin bad++; $display("FAIL thr_pend_ev%0d: got %b want %b", i, pending[0], (i == 4)); end
    end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL thr_irq: got %b want 1", irq); end
    read_chan(0);
    total++; if (rd_count !== 8'd4 || rd_vo !== 1'b1) begin bad++; $display("FAIL thr_count: got cnt=%0d v=%b want cnt=4 v=1", rd_count, rd_vo); end
  endtask

  task automatic test_timeout();
    do_reset();
    cfg_write(1, 1, 8'd10, 16'd20);
    pulse(2'b10);
    for (int k = 1; k <= 21; k++) begin
      step();
      total++; if (pending[1] !== (k == 21)) begin bad++; $display("FAIL tmo_pend_k%0d: got %b want %b", k, pending[1], (k == 21)); end
    end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL tmo_irq: got %b want 1", irq); end
    clear_v = 1; clear_chan = 1;
    step();
    clear_v = 0;
    total++; if (pending[1] !== 1'b0 || irq !== 1'b0) begin bad++; $display("FAIL tmo_clear: got pend=%b irq=%b want 0 0", pending[1], irq); end
    read_chan(1);
    total++; if (rd_count !== 8'd0) begin bad++; $display("FAIL tmo_clear_count: got %0d want 0", rd_count); end
  endtask

  task automatic test_clear_event();
    do_reset();
    cfg_write(0, 1, 8'd4, 16'd0);
    repeat (4) pulse(2'b01);
    total++; if (pending[0] !== 1'b1) begin bad++; $display("FAIL clr_ev_pre: got %b want 1", pending[0]); end
    clear_v = 1; clear_chan = 0; event_v = 2'b01;
    step();
    clear_v = 0; event_v = '0;
    total++; if (pending[0] !== 1'b0 || irq !== 1'b0) begin bad++; $display("FAIL clr_ev_pend: got pend=%b irq=%b want 0 0", pending[0], irq); end
    total++; if (dbg[1:0] !== 2'd1) begin bad++; $display("FAIL clr_ev_state: got %0d want 1", dbg[1:0]); end
    read_chan(0);
    total++; if (rd_count !== 8'd1) begin bad++; $display("FAIL clr_ev_count: got %0d want 1", rd_count); end
  endtask

  task automatic test_saturate();
    do_reset();
    cfg_chan = 0; cfg_en = 1; cfg_tmo = '0; thr2 = 2'd0; cfg2_v = 1;
    step();
    cfg2_v = 0;
    for (int i = 1; i <= 6; i++) begin
      ev2 = 2'b01; rd2_v = 1; rd_chan = 0;
      step();
      ev2 = '0; rd2_v = 0;
      total++; if (pend2[0] !== 1'b1 || irq2 !== 1'b1) begin bad++; $display("FAIL sat_pend_ev%0d: got pend=%b irq=%b want 1 1", i, pend2[0], irq2); end
      total++; if (rd2_count !== 2'(((i - 1) < 3) ? (i - 1) : 3)) begin bad++; $display("FAIL sat_count_ev%0d: got %0d want %0d", i, rd2_count, ((i - 1) < 3) ? (i - 1) : 3); end
    end
    rd2_v = 1;
    step();
    rd2_v = 0;
    total++; if (rd2_count !== 2'd3) begin bad++; $display("FAIL sat_final: got %0d want 3", rd2_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cfg_write(0, 1, 8'd1, 16'd0);
    cfg_write(1, 1, 8'd10, 16'd0);
    pulse(2'b11);
    read_chan(0);
    total++; if (pending !== 2'b01 || irq !== 1'b1 || rd_count !== 8'd1) begin bad++; $display("FAIL arst_pre: got pend=%b irq=%b cnt=%0d want 01 1 1", pending, irq, rd_count); end
    total++; if (dbg[3:2] !== 2'd1) begin bad++; $display("FAIL arst_pre_state: got %0d want 1", dbg[3:2]); end
    rd_v = 1; rd_chan = 1;
    @(posedge clk);
    #3;
    rd_v = 0;
    reset_n = 0;
    #1;
    total++; if (pending !== 2'b00 || irq !== 1'b0 || rd_vo !== 1'b0 || rd_count !== 8'd0) begin bad++; $display("FAIL arst_async: got pend=%b irq=%b v=%b cnt=%0d want all 0", pending, irq, rd_vo, rd_count); end
    total++; if (dbg !== 4'd0) begin bad++; $display("FAIL arst_state: got %h want 0", dbg); end
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1;
    pulse(2'b10);
    read_chan(1);
    total++; if (rd_count !== 8'(m_rd_count) || pending !== exp_pend()) begin bad++; $display("FAIL arst_ignored: got cnt=%0d pend=%b want cnt=%0d pend=%b", rd_count, pending, m_rd_count, exp_pend()); end
    cfg_write(1, 1, 8'd10, 16'd0);
    pulse(2'b10);
    read_chan(1);
    total++; if (rd_count !== 8'd1 || dbg[3:2] !== 2'd1) begin bad++; $display("FAIL arst_reenable: got cnt=%0d st=%0d want 1 1", rd_count, dbg[3:2]); end
  endtask

  task automatic test_disable_pend();
    do_reset();
    cfg_write(0, 1, 8'd2, 16'd0);
    repeat (2) pulse(2'b01);
    total++; if (pending[0] !== 1'b1) begin bad++; $display("FAIL dis_pre: got %b want 1", pending[0]); end
    cfg_write(0, 0, 8'd2, 16'd0);
    total++; if (pending[0] !== 1'b0 || irq !== 1'b0) begin bad++; $display("FAIL dis_pend: got pend=%b irq=%b want 0 0", pending[0], irq); end
    repeat (5) pulse(2'b01);
    read_chan(0);
    total++; if (rd_count !== 8'd0) begin bad++; $display("FAIL dis_count: got %0d want 0", rd_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cfg_write(0, 1, 8'($urandom_range(0, 6)), 16'($urandom_range(0, 12)));
    cfg_write(1, 1, 8'($urandom_range(0, 6)), 16'($urandom_range(0, 12)));
    for (int i = 0; i < 800; i++) begin
      event_v    = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      cfg_v      = ($urandom_range(0, 24) == 0);
      cfg_chan   = 1'($urandom_range(0, 1));
      cfg_en     = ($urandom_range(0, 4) != 0);
      cfg_thr    = 8'($urandom_range(0, 6));
      cfg_tmo    = 16'($urandom_range(0, 12));
      clear_v    = ($urandom_range(0, 9) == 0);
      clear_chan = 1'($urandom_range(0, 1));
      rd_v       = ($urandom_range(0, 2) == 0);
      rd_chan    = 1'($urandom_range(0, 1));
      step();
      total++; if (pending !== exp_pend()) begin bad++; $display("FAIL rand_pend cyc%0d: got %b want %b", i, pending, exp_pend()); end
      total++; if (irq !== (|exp_pend())) begin bad++; $display("FAIL rand_irq cyc%0d: got %b want %b", i, irq, |exp_pend()); end
      total++; if (rd_vo !== 1'(m_rd_v) || rd_count !== 8'(m_rd_count)) begin bad++; $display("FAIL rand_rd cyc%0d: got v=%b cnt=%0d want v=%0d cnt=%0d", i, rd_vo, rd_count, m_rd_v, m_rd_count); end
    end
    idle_inputs();
  endtask

  initial begin
    reset_n = 0;
    idle_inputs();
    test_reset();
    test_threshold();
    test_timeout();
    test_clear_event();
    test_saturate();
    test_async_reset();
    test_disable_pend();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_irq_coalesce_unit.md
ETH_IRQ_COALESCE_UNIT -- requirements
Module: eth_irq_coalesce_unit

Interface
REQ-001 Parameter channels_p, default 2, number of interrupt channels (channel 0 = RX, channel 1 = TX).
REQ-002 Parameter count_width_p, default 8, width of the per-channel event counter and threshold.
REQ-003 Parameter timer_width_p, default 16, width of the per-channel timeout timer and timeout value.
REQ-004 clk_i  in  1  the block's only clock; all state updates on its rising edge.
REQ-005 reset_n_i  in  1  asynchronous, active-low reset.
REQ-006 event_v_i  in  channels_p  one-cycle pulse per channel event (packet received / TX buffer freed).
REQ-007 cfg_v_i  in  1  configuration write strobe.
REQ-008 cfg_chan_i  in  clog2(channels_p)  channel selected by cfg_v_i.
REQ-009 cfg_enable_i  in  1  channel enable value to write.
REQ-010 cfg_threshold_i  in  count_width_p  event-count threshold to write.
REQ-011 cfg_timeout_i  in  timer_width_p  timeout in clk_i cycles to write; 0 disables the timer.
REQ-012 clear_v_i  in  1  clear strobe (software acknowledge).
REQ-013 clear_chan_i  in  clog2(channels_p)  channel selected by clear_v_i.
REQ-014 rd_v_i  in  1  status read strobe.
REQ-015 rd_chan_i  in  clog2(channels_p)  channel selected by rd_v_i.
REQ-016 rd_count_o  out  count_width_p  registered event count of the read channel.
REQ-017 rd_v_o  out  1  high one cycle after rd_v_i.
REQ-018 pending_o  out  channels_p  registered per-channel interrupt pending.
REQ-019 irq_o  out  1  registered OR of all pending_o bits.

Function
REQ-020 Each channel SHALL run an FSM with states IDLE (count 0), ACCUM (count > 0, timer running) and PEND (pending_o bit high).
REQ-021 IDLE -> ACCUM on an event when enabled; ACCUM -> PEND when the incremented count is at least the threshold, or when the timer equals a nonzero timeout; PEND -> IDLE only on a clear.
REQ-022 An enabled channel SHALL increment its count by 1 per event in every state, saturating at 2^count_width_p-1.
REQ-023 A threshold of 0 SHALL behave as a threshold of 1.
REQ-024 pending_o SHALL rise in the cycle after the qualifying event or timer expiry, giving 1-cycle latency; irq_o SHALL follow pending_o in the same cycle.
REQ-025 The timer SHALL be zeroed on entry to ACCUM and increment once per cycle while in ACCUM; it is frozen in IDLE and PEND.
REQ-026 On a clear, the selected channel SHALL go to IDLE, with count 0, timer 0 and pending 0.
REQ-027 When a clear and an event hit the same channel in the same cycle, the clear SHALL apply first, leaving count 1 and state ACCUM (or PEND if threshold ≤ 1).
REQ-028 A config write SHALL take effect the next cycle; writing enable=0 SHALL force the channel to IDLE, and a disabled channel ignores events.
REQ-029 A config write of enable=1 to a channel in ACCUM or PEND SHALL keep its state and count; the new threshold and timeout apply from the next cycle.
REQ-030 When a config write and a clear target the same channel in the same cycle, both SHALL apply.
REQ-031 A read SHALL return the channel's count as it was before the same-cycle update.
REQ-032 Events on different channels in the same cycle SHALL be processed independently.

Reset
REQ-033 Asserting reset_n_i low SHALL immediately set, per channel: state IDLE, count 0, timer 0, enable 0, threshold 1, timeout 0; and SHALL immediately set pending_o, irq_o, rd_v_o and rd_count_o to 0.
REQ-034 Reset asserted mid-accumulation or while pending SHALL discard all events; after reset release, behaviour starts from the REQ-033 state.

Verification
REQ-035 Channel 0 configured with enable 1, threshold 4, timeout 0; 4 event pulses sent -> pending_o[0]=1 and irq_o=1 one cycle after the 4th pulse, with rd_count_o=4.
REQ-036 Channel 1 configured with threshold 10, timeout 20; 1 event sent -> pending_o[1] rises 21 cycles after the event; a clear drops it next cycle, with count 0.
REQ-037 Channel 0 pending, with clear and event in the same cycle, threshold 4 -> pending_o[0]=0 and count=1 next cycle, state ACCUM.
REQ-038 count_width_p=2, threshold 0, 6 events without a clear -> pending after the 1st event; count saturates at 3.
REQ-039 reset_n_i pulsed low while channel 1 is in ACCUM -> outputs go 0 without waiting for a clock edge; a post-reset event is ignored until re-enabled.
REQ-040 Channel 0 disabled while in PEND -> pending_o[0]=0 next cycle; 5 subsequent events leave count 0.
